// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
//
// Memory-access stage controller for the 5-stage pipeline. It takes the
// MEM-stage outputs of the EX/MEM register, issues loads and stores on the
// data-memory request/response bus, and holds the front of the pipeline with
// mem_stall until the access finishes. It also owns the MEM/WB register.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   MEM_alu_out         effective address (ld/str) or ALU result (others)
//   MEM_b2              store data
//   MEM_rd, MEM_we      destination register and its write enable
//   MEM_ld, MEM_str     load / store (both high behaves as a load)
//   MEM_byt             byte access when high, word access otherwise
//   dmem_req/wr/addr/wdata/be   request side of the data-memory bus
//   dmem_gnt            request accepted this cycle
//   dmem_rvalid/rdata   read response
//   mem_stall           freezes IF/ID/EX and the EX/MEM register
//   WB_rd, WB_we, WB_data       MEM/WB register outputs
//
// The byte-lane logic assumes four lanes, so XLEN is expected to stay 32.
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic [XLEN-1:0] MEM_alu_out,
  input  logic [XLEN-1:0] MEM_b2,
  input  logic [4:0]      MEM_rd,
  input  logic            MEM_we,
  input  logic            MEM_ld,
  input  logic            MEM_str,
  input  logic            MEM_byt,

  output logic            dmem_req,
  output logic            dmem_wr,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,

  output logic            mem_stall,

  output logic [4:0]      WB_rd,
  output logic            WB_we,
  output logic [XLEN-1:0] WB_data
);

  typedef enum logic {
    IDLE,
    WAIT_R
  } state_t;

  state_t          state;
  state_t          state_next;

  logic            access;
  logic            is_load;
  logic            is_store;
  logic            granted;
  logic            done;
  logic [1:0]      lane;
  logic [7:0]      load_byte;
  logic [XLEN-1:0] load_data;

  // Decode the access type. A load takes priority when both ld and str are
  // set, so the store half of such an instruction is simply dropped.
  assign access   = MEM_ld | MEM_str;
  assign is_load  = MEM_ld;
  assign is_store = MEM_str & ~MEM_ld;
  assign lane     = MEM_alu_out[1:0];

  // A grant only counts while we are actually requesting, so a stray gnt
  // during reset or between accesses can never complete anything.
  assign granted  = dmem_req & dmem_gnt;

  // State register. Reset always returns to IDLE, which also abandons any
  // read still in flight; its late rvalid is then ignored in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, request and completion logic. Stores finish on their grant;
  // loads finish on the read response after moving to WAIT_R.
  always_comb begin
    state_next = state;
    dmem_req   = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        dmem_req = access & ~rst;
        if (granted && is_store) begin
          done = 1'b1;
        end
        if (granted && is_load) begin
          state_next = WAIT_R;
        end
      end
      WAIT_R: begin
        if (dmem_rvalid) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stall whenever a memory instruction sits in MEM and has not finished
  // this cycle; the stall drops in the completing cycle itself.
  assign mem_stall = access & ~done & ~rst;

  // Request attributes depend only on the held MEM_* inputs, so they stay
  // stable for as long as a request waits for its grant.
  always_comb begin
    dmem_wr = is_store;
    if (MEM_byt) begin
      dmem_addr  = MEM_alu_out;
      dmem_be    = 4'b0001 << lane;
      dmem_wdata = {4{MEM_b2[7:0]}};
    end else begin
      dmem_addr  = {MEM_alu_out[XLEN-1:2], 2'b00};
      dmem_be    = 4'b1111;
      dmem_wdata = MEM_b2;
    end
  end

  // Load data formatting: byte loads pick the addressed lane and
  // zero-extend it; word loads pass the bus data straight through.
  always_comb begin
    load_byte = dmem_rdata[{lane, 3'b000} +: 8];
    if (MEM_byt) begin
      load_data = {{(XLEN-8){1'b0}}, load_byte};
    end else begin
      load_data = dmem_rdata;
    end
  end

  // MEM/WB register. While stalled, a bubble goes downstream (write enable
  // cleared) and the rest holds. Otherwise the instruction retires; writes
  // to x0 are suppressed here so writeback never needs to check.
  always_ff @(posedge clk) begin
    if (rst) begin
      WB_rd   <= 5'd0;
      WB_we   <= 1'b0;
      WB_data <= '0;
    end else if (mem_stall) begin
      WB_we   <= 1'b0;
    end else begin
      WB_rd   <= MEM_rd;
      WB_we   <= MEM_we & (MEM_rd != 5'd0);
      WB_data <= is_load ? load_data : MEM_alu_out;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
//
// Directed testbench for mem_stage_ctrl. Stimulus pushes hand-computed
// expected bus requests and writebacks into queues; a monitor pops and
// compares them whenever the DUT presents a request or retires an
// instruction. A small bus responder provides configurable grant and
// read-response latency.
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    int          stall;
  } wb_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] MEM_alu_out = '0;
  logic [31:0] MEM_b2 = '0;
  logic [4:0]  MEM_rd = '0;
  logic        MEM_we = 1'b0;
  logic        MEM_ld = 1'b0;
  logic        MEM_str = 1'b0;
  logic        MEM_byt = 1'b0;
  logic        dmem_req;
  logic        dmem_wr;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [4:0]  WB_rd;
  logic        WB_we;
  logic [31:0] WB_data;

  int vectors = 0;
  int miscompares = 0;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];

  // bus responder configuration and state
  int          cfg_gd = 0;
  int          cfg_rdl = 1;
  logic [31:0] cfg_rdata = '0;
  int          req_wait = 0;
  int          r_cnt = 0;
  logic        r_pending = 1'b0;

  // monitor state
  logic        instr_active = 1'b0;
  logic        retire_pending = 1'b0;
  int          stall_cnt = 0;
  int          seen_stall = 0;
  wb_exp_t     wb_e;
  bus_exp_t    bus_e;

  mem_stage_ctrl #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_alu_out (MEM_alu_out),
    .MEM_b2      (MEM_b2),
    .MEM_rd      (MEM_rd),
    .MEM_we      (MEM_we),
    .MEM_ld      (MEM_ld),
    .MEM_str     (MEM_str),
    .MEM_byt     (MEM_byt),
    .dmem_req    (dmem_req),
    .dmem_wr     (dmem_wr),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .mem_stall   (mem_stall),
    .WB_rd       (WB_rd),
    .WB_we       (WB_we),
    .WB_data     (WB_data)
  );

  always #5 clk = ~clk;

  // Bus responder: grant after cfg_gd waiting cycles, read data cfg_rdl
  // cycles after the grant. It is deliberately not reset, so a read in
  // flight across a DUT reset still delivers a stale response.
  assign dmem_gnt    = dmem_req && (req_wait >= cfg_gd);
  assign dmem_rvalid = r_pending && (r_cnt == cfg_rdl);
  assign dmem_rdata  = dmem_rvalid ? cfg_rdata : 32'hFFFF_FFFF;

  always @(posedge clk) begin
    if (dmem_req && !dmem_gnt) req_wait <= req_wait + 1;
    else                       req_wait <= 0;
    if (dmem_req && dmem_gnt && !dmem_wr) begin
      r_pending <= 1'b1;
      r_cnt     <= 1;
    end else if (dmem_rvalid) begin
      r_pending <= 1'b0;
    end else if (r_pending) begin
      r_cnt <= r_cnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: compares every request cycle against the head of the bus
  // queue (popped on grant) and each retired instruction's MEM/WB contents
  // and stall-cycle count one cycle after its stall drops.
  always @(negedge clk) begin
    if (retire_pending) begin
      retire_pending = 1'b0;
      if (wb_q.size() == 0) begin
        checkOutput("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_e = wb_q.pop_front();
        checkOutput("WB_rd", {27'd0, WB_rd}, {27'd0, wb_e.rd});
        checkOutput("WB_we", {31'd0, WB_we}, {31'd0, wb_e.we});
        checkOutput("WB_data", WB_data, wb_e.data);
        checkOutput("stall_cycles", 32'(seen_stall), 32'(wb_e.stall));
      end
    end
    if (rst) begin
      stall_cnt = 0;
    end else if (instr_active) begin
      if (mem_stall) begin
        stall_cnt++;
      end else begin
        retire_pending = 1'b1;
        seen_stall     = stall_cnt;
        stall_cnt      = 0;
      end
    end
    if (dmem_req) begin
      if (bus_q.size() == 0) begin
        checkOutput("bus_unexpected_req", 32'd1, 32'd0);
      end else begin
        bus_e = bus_q[0];
        checkOutput("dmem_wr", {31'd0, dmem_wr}, {31'd0, bus_e.wr});
        checkOutput("dmem_addr", dmem_addr, bus_e.addr);
        checkOutput("dmem_be", {28'd0, dmem_be}, {28'd0, bus_e.be});
        checkOutput("dmem_wdata", dmem_wdata, bus_e.wdata);
        if (dmem_gnt) void'(bus_q.pop_front());
      end
    end
  end

  // Issue one instruction with hand-computed expectations and hold it until
  // the DUT stops stalling; the next instruction follows back-to-back.
  task automatic applyStimulus(
    input logic ld, input logic str, input logic byt, input logic we,
    input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] b2,
    input int gd, input int rdl, input logic [31:0] rdata,
    input logic [31:0] exp_addr, input logic [3:0] exp_be,
    input logic [31:0] exp_wdata, input logic exp_we,
    input logic [31:0] exp_data, input int exp_stall);
    int n;
    if (ld || str) bus_q.push_back('{str & ~ld, exp_addr, exp_be, exp_wdata});
    wb_q.push_back('{rd, exp_we, exp_data, exp_stall});
    cfg_gd = gd; cfg_rdl = rdl; cfg_rdata = rdata;
    MEM_ld = ld; MEM_str = str; MEM_byt = byt; MEM_we = we;
    MEM_rd = rd; MEM_alu_out = alu; MEM_b2 = b2;
    instr_active = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (!mem_stall) break;
      n++;
      if (n > 40) begin
        checkOutput("stall_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    MEM_ld = 1'b0; MEM_str = 1'b0; MEM_byt = 1'b0; MEM_we = 1'b0;
    MEM_rd = '0; MEM_alu_out = '0; MEM_b2 = '0;
    instr_active = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting mem_stage_ctrl bench");
    // reset with a load presented: no request, no stall, MEM/WB cleared
    MEM_ld = 1'b1; MEM_alu_out = 32'h44; MEM_rd = 5'd9; MEM_we = 1'b1;
    @(negedge clk);
    checkOutput("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk);
    checkOutput("rst_WB_rd", {27'd0, WB_rd}, 32'd0);
    checkOutput("rst_WB_we", {31'd0, WB_we}, 32'd0);
    checkOutput("rst_WB_data", WB_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; MEM_ld = 1'b0; MEM_alu_out = '0; MEM_rd = '0; MEM_we = 1'b0;

    //           ld   str  byt  we   rd     alu            b2             gd rdl rdata          addr           be       wdata          wbwe  wbdata         stall
    applyStimulus(1'b0,1'b1,1'b0,1'b0,5'd0, 32'h0000_0103, 32'hDEAD_BEEF, 0, 1, 32'h0,         32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0000_0103, 0);
    applyStimulus(1'b0,1'b1,1'b1,1'b0,5'd0, 32'h0000_0102, 32'h1234_5678, 2, 1, 32'h0,         32'h0000_0102, 4'b0100, 32'h7878_7878, 1'b0, 32'h0000_0102, 2);
    applyStimulus(1'b1,1'b0,1'b1,1'b1,5'd5, 32'h0000_0201, 32'h0,         0, 3, 32'hAABB_CCDD, 32'h0000_0201, 4'b0010, 32'h0,         1'b1, 32'h0000_00CC, 3);
    applyStimulus(1'b0,1'b0,1'b0,1'b1,5'd0, 32'h0000_0007, 32'h0,         0, 1, 32'h0,         32'h0,         4'b0000, 32'h0,         1'b0, 32'h0000_0007, 0);
    applyStimulus(1'b1,1'b0,1'b0,1'b1,5'd10,32'h0000_040C, 32'h0,         1, 1, 32'h0123_4567, 32'h0000_040C, 4'b1111, 32'h0,         1'b1, 32'h0123_4567, 2);
    applyStimulus(1'b1,1'b0,1'b1,1'b1,5'd31,32'h0000_0007, 32'h0,         0, 1, 32'h80FF_0011, 32'h0000_0007, 4'b1000, 32'h0,         1'b1, 32'h0000_0080, 1);
    applyStimulus(1'b0,1'b0,1'b0,1'b1,5'd3, 32'hCAFE_F00D, 32'h0,         0, 1, 32'h0,         32'h0,         4'b0000, 32'h0,         1'b1, 32'hCAFE_F00D, 0);
    applyStimulus(1'b1,1'b1,1'b0,1'b1,5'd4, 32'h0000_0500, 32'h1111_1111, 0, 1, 32'h55AA_55AA, 32'h0000_0500, 4'b1111, 32'h1111_1111, 1'b1, 32'h55AA_55AA, 1);
    applyStimulus(1'b0,1'b1,1'b0,1'b1,5'd2, 32'h0000_0012, 32'h0000_0009, 0, 1, 32'h0,         32'h0000_0010, 4'b1111, 32'h0000_0009, 1'b1, 32'h0000_0012, 0);

    // let the last retirement be checked by the monitor
    @(negedge clk);
    @(negedge clk);

    // reset while a load waits for data; the late response must be dropped
    cfg_gd = 0; cfg_rdl = 4; cfg_rdata = 32'hFFFF_FFFF;
    bus_q.push_back('{1'b0, 32'h0000_0300, 4'b1111, 32'h0});
    @(posedge clk); #1;
    MEM_ld = 1'b1; MEM_alu_out = 32'h300; MEM_rd = 5'd6; MEM_we = 1'b1;
    @(negedge clk);
    checkOutput("midrst_stall_gnt", {31'd0, mem_stall}, 32'd1);
    @(negedge clk);
    checkOutput("midrst_stall_wait", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; MEM_ld = 1'b0; MEM_alu_out = '0; MEM_rd = '0; MEM_we = 1'b0;
    @(negedge clk);
    checkOutput("midrst_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("midrst_stall_rst", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("post_rst_stall", {31'd0, mem_stall}, 32'd0);
      checkOutput("post_rst_WB_we", {31'd0, WB_we}, 32'd0);
      checkOutput("post_rst_WB_data", WB_data, 32'd0);
    end
    checkOutput("stale_rvalid_seen", {31'd0, r_pending}, 32'd0);

    checkOutput("bus_q_empty", 32'(bus_q.size()), 32'd0);
    checkOutput("wb_q_empty", 32'(wb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
